seg_scan_controller: RTL

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_next_digit.sv | 26 ++
 rtl/seg_scan_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// SEG_SCAN_BLANK_EN adds the inter-digit BLANK state to the state type.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'hF;

`ifdef SEG_SCAN_BLANK_EN
  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StBlank
  } scan_state_e;
`else
  typedef enum logic [0:0] {
    StIdle,
    StActive
  } scan_state_e;
`endif

  function automatic logic [1:0] onehot_to_index(input logic [NUM_DIGITS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Rotating next-digit search: returns the first enabled digit after the current one,
// wrapping 3->0; the current digit is the last candidate, and an empty mask holds it.
module seg_next_digit
  import seg_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] current_sel,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [NUM_DIGITS-1:0] next_sel
);

  logic [2*NUM_DIGITS-1:0] rot;
  logic [NUM_DIGITS-1:0]   cand;

  // Walk rotations from farthest to nearest so the nearest enabled candidate wins.
  always_comb begin
    next_sel = current_sel;
    rot      = '0;
    cand     = '0;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      rot  = {current_sel, current_sel} << k;
      cand = rot[2*NUM_DIGITS-1:NUM_DIGITS];
      if (|(cand & mask)) next_sel = cand;
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment digit scanner with registered select/anode outputs.
// Define SEG_SCAN_BLANK_EN to insert BLANK_CYCLES of dark time between digits.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] select,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic [1:0]            digit_index,
  output logic                  tick,
  output logic                  blank
);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg_scan_controller: PRESCALE must be at least 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_scan_controller: BLANK_CYCLES must be at least 1");
  end

  localparam int unsigned PrescW = $clog2(PRESCALE);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);

  scan_state_e           state_q, state_d;
  logic [PrescW-1:0]     presc_q, presc_d;
  logic [NUM_DIGITS-1:0] select_q, select_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [1:0]            index_q;
  logic                  tick_q, tick_d;
  logic                  blank_q;
  logic [NUM_DIGITS-1:0] nd_cur, nd_next;

`ifdef SEG_SCAN_BLANK_EN
  localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  logic [BlankW-1:0] blank_cnt_q, blank_cnt_d;
`endif

  // Seeding with the top digit makes the rotation yield the lowest enabled digit.
  assign nd_cur = (state_q == StIdle) ? {1'b1, {(NUM_DIGITS - 1){1'b0}}} : select_q;

  seg_next_digit u_next_digit (
    .current_sel (nd_cur),
    .mask        (digit_en),
    .next_sel    (nd_next)
  );

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    select_d = select_q;
    tick_d   = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
    blank_cnt_d = blank_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (enable && |digit_en) begin
          select_d = nd_next;
          tick_d   = 1'b1;
          presc_d  = '0;
`ifdef SEG_SCAN_BLANK_EN
          state_d     = StBlank;
          blank_cnt_d = '0;
`else
          state_d = StActive;
`endif
        end
      end
      StActive: begin
        if (!enable) begin
          state_d = StIdle;
          presc_d = '0;
        end else if (presc_q != PrescLast) begin
          presc_d = presc_q + 1'b1;
        end else begin
          presc_d = '0;
          if (digit_en == '0) begin
            state_d = StIdle;
          end else begin
            select_d = nd_next;
            tick_d   = 1'b1;
`ifdef SEG_SCAN_BLANK_EN
            state_d     = StBlank;
            blank_cnt_d = '0;
`endif
          end
        end
      end
`ifdef SEG_SCAN_BLANK_EN
      StBlank: begin
        if (!enable) begin
          state_d     = StIdle;
          blank_cnt_d = '0;
        end else if (blank_cnt_q != BlankLast) begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end else begin
          state_d     = StActive;
          blank_cnt_d = '0;
          presc_d     = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Anodes decode from select_q: without blanking this trails select by one edge,
    // with blanking select_q already equals select_d whenever ACTIVE continues.
    anode_d = ANODES_OFF;
    if (state_d == StActive && state_q != StIdle) anode_d = ~(select_q & digit_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      select_q <= {{(NUM_DIGITS - 1){1'b0}}, 1'b1};
      anode_q  <= ANODES_OFF;
      index_q  <= 2'd0;
      tick_q   <= 1'b0;
      blank_q  <= 1'b1;
`ifdef SEG_SCAN_BLANK_EN
      blank_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      select_q <= select_d;
      anode_q  <= anode_d;
      index_q  <= onehot_to_index(select_d);
      tick_q   <= tick_d;
      blank_q  <= (anode_d == ANODES_OFF);
`ifdef SEG_SCAN_BLANK_EN
      blank_cnt_q <= blank_cnt_d;
`endif
    end
  end

  assign select      = select_q;
  assign anode_n     = anode_q;
  assign digit_index = index_q;
  assign tick        = tick_q;
  assign blank       = blank_q;

endmodule
